// File: rtl/interval_timer_pkg.sv
// Shared types for the interval timer: FSM state encoding.
package interval_timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/interval_timer_if.sv
// Configuration channel of the interval timer.
// Handshake: a transfer happens on a rising clk edge where cfg_valid and cfg_ready are both 1;
// the master holds cfg_period/cfg_oneshot stable while cfg_valid is high, and cfg_ready does not depend on cfg_valid.
interface interval_timer_if #(
  parameter int N = 16
) ();

  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_period;
  logic         cfg_oneshot;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_oneshot,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_oneshot,
    output cfg_ready
  );

endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer: periodic or one-shot ticks every period_reg ce-cycles,
// configured over a valid/ready channel and controlled by start/stop strobes.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                sreset,
  input  logic                ce,
  interval_timer_if.slave     cfg_if,
  input  logic                start,
  input  logic                stop,
  output logic [N-1:0]        count,
  output logic                running,
  output logic                tick,
  output logic                done,
  output timer_state_t        state_dbg
);

  timer_state_t state;
  logic [N-1:0] period_reg;
  logic         oneshot_reg;

  logic         xfer;
  logic [N-1:0] eff_period;
  logic [N-1:0] last_count;

  assign cfg_if.cfg_ready = (state != RUN);
  assign xfer             = cfg_if.cfg_valid & cfg_if.cfg_ready;
  // A start in the same cycle as a transfer must see the newly offered period.
  assign eff_period       = xfer ? cfg_if.cfg_period : period_reg;
  // period_reg is never zero while in RUN, so this cannot underflow where it matters.
  assign last_count       = period_reg - N'(1);

  assign running   = (state == RUN);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (sreset) begin
      state       <= IDLE;
      period_reg  <= '0;
      oneshot_reg <= 1'b0;
      count       <= '0;
      tick        <= 1'b0;
      done        <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (xfer) begin
            period_reg  <= cfg_if.cfg_period;
            oneshot_reg <= cfg_if.cfg_oneshot;
            if (state == DONE) begin
              state <= IDLE;
              done  <= 1'b0;
            end
          end
          if (start && !stop && (eff_period != '0)) begin
            state <= RUN;
            count <= '0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            count <= '0;
          end else if (ce) begin
            if (count == last_count) begin
              count <= '0;
              tick  <= 1'b1;
              if (oneshot_reg) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              count <= count + N'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer (N=8 so the maximum period stays short).
module tb_interval_timer;
  import interval_timer_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         sreset = 1'b0;
  logic         ce = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [N-1:0] count;
  logic         running;
  logic         tick;
  logic         done;
  timer_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  interval_timer_if #(.N(N)) cfg_if ();

  interval_timer #(.N(N)) dut (
    .clk       (clk),
    .sreset    (sreset),
    .ce        (ce),
    .cfg_if    (cfg_if.slave),
    .start     (start),
    .stop      (stop),
    .count     (count),
    .running   (running),
    .tick      (tick),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [N-1:0] p, input logic os);
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_period  = p;
    cfg_if.cfg_oneshot = os;
    step();
    cfg_if.cfg_valid   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    sreset = 1'b1;
    step();
    sreset = 1'b0;
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_if.cfg_ready); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_dbg, IDLE); end
  endtask

  task automatic test_periodic();
    logic [N-1:0] exp_cnt [8] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    logic         exp_tck [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_cfg(8'd4, 1'b0);
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_idle got %b exp 1", cfg_if.cfg_ready); end
    ce = 1'b1;
    do_start();
    checks++; if (running !== 1'b1 || count !== 8'd0 || tick !== 1'b0) begin
      errors++; $display("FAIL periodic_start running=%b count=%0d tick=%b exp 1/0/0", running, count, tick); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (count !== exp_cnt[i] || tick !== exp_tck[i]) begin
        errors++; $display("FAIL periodic_seq[%0d] count=%0d tick=%b exp %0d/%b", i, count, tick, exp_cnt[i], exp_tck[i]); end
    end
    do_stop();
    checks++; if (running !== 1'b0 || count !== 8'd0 || tick !== 1'b0) begin
      errors++; $display("FAIL periodic_stop running=%b count=%0d tick=%b exp 0/0/0", running, count, tick); end
  endtask

  task automatic test_oneshot();
    logic [N-1:0] exp_cnt [3] = '{8'd1, 8'd2, 8'd0};
    logic         exp_tck [3] = '{1'b0, 1'b0, 1'b1};
    do_cfg(8'd3, 1'b1);
    do_start();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (count !== exp_cnt[i] || tick !== exp_tck[i]) begin
        errors++; $display("FAIL oneshot_seq[%0d] count=%0d tick=%b exp %0d/%b", i, count, tick, exp_cnt[i], exp_tck[i]); end
    end
    checks++; if (state_dbg !== DONE || done !== 1'b1 || running !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL oneshot_done state=%0d done=%b running=%b ready=%b exp 2/1/0/1", state_dbg, done, running, cfg_if.cfg_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (tick !== 1'b0 || done !== 1'b1 || count !== 8'd0) begin
        errors++; $display("FAIL oneshot_after[%0d] tick=%b done=%b count=%0d exp 0/1/0", i, tick, done, count); end
    end
    do_stop();
    checks++; if (done !== 1'b1 || state_dbg !== DONE) begin
      errors++; $display("FAIL stop_in_done done=%b state=%0d exp 1/2", done, state_dbg); end
  endtask

  task automatic test_ignored();
    do_cfg(8'd0, 1'b0);
    checks++; if (state_dbg !== IDLE || done !== 1'b0) begin
      errors++; $display("FAIL cfg_in_done state=%0d done=%b exp 0/0", state_dbg, done); end
    do_start();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_period0 running=%b exp 0", running); end
    do_cfg(8'd5, 1'b0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_and_stop running=%b exp 0", running); end
    do_start();
    checks++; if (running !== 1'b1 || cfg_if.cfg_ready !== 1'b0) begin
      errors++; $display("FAIL run_ready running=%b ready=%b exp 1/0", running, cfg_if.cfg_ready); end
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = 8'd2; cfg_if.cfg_oneshot = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++; if (count !== 8'd1) begin errors++; $display("FAIL cfg_in_run count=%0d exp 1", count); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (count !== 8'd4 || tick !== 1'b0) begin
      errors++; $display("FAIL cfg_in_run_p5 count=%0d tick=%b exp 4/0", count, tick); end
    step();
    checks++; if (count !== 8'd0 || tick !== 1'b1 || running !== 1'b1) begin
      errors++; $display("FAIL cfg_in_run_wrap count=%0d tick=%b running=%b exp 0/1/1", count, tick, running); end
    do_stop();
  endtask

  task automatic test_edge_periods();
    int ticks;
    do_cfg(8'd1, 1'b0);
    do_start();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (count !== 8'd0 || tick !== 1'b1) begin
        errors++; $display("FAIL p1[%0d] count=%0d tick=%b exp 0/1", i, count, tick); end
    end
    do_stop();
    do_cfg(8'd255, 1'b0);
    do_start();
    for (int i = 1; i <= 254; i++) begin
      step();
      checks++; if (count !== 8'(i) || tick !== 1'b0) begin
        errors++; $display("FAIL pmax[%0d] count=%0d tick=%b exp %0d/0", i, count, tick, i); end
    end
    step();
    checks++; if (count !== 8'd0 || tick !== 1'b1) begin
      errors++; $display("FAIL pmax_wrap count=%0d tick=%b exp 0/1", count, tick); end
    do_stop();
    do_cfg(8'd2, 1'b0);
    ce = 1'b0;
    do_start();
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      ce = (k % 2 == 0);
      step();
      if (tick === 1'b1) ticks++;
      checks++; if (count !== (((k % 4) == 0 || (k % 4) == 1) ? 8'd1 : 8'd0) || tick !== ((k % 4) == 2)) begin
        errors++; $display("FAIL ce_gate[%0d] count=%0d tick=%b", k, count, tick); end
    end
    checks++; if (ticks !== 2) begin errors++; $display("FAIL ce_gate_ticks got %0d exp 2", ticks); end
    ce = 1'b1;
    step();
    checks++; if (count !== 8'd1) begin errors++; $display("FAIL pre_term count=%0d exp 1", count); end
    do_stop();
    checks++; if (tick !== 1'b0 || running !== 1'b0 || count !== 8'd0) begin
      errors++; $display("FAIL stop_at_term tick=%b running=%b count=%0d exp 0/0/0", tick, running, count); end
  endtask

  task automatic test_mid_reset();
    do_cfg(8'd5, 1'b0);
    do_start();
    step(); step();
    checks++; if (count !== 8'd2) begin errors++; $display("FAIL pre_reset count=%0d exp 2", count); end
    sreset = 1'b1;
    step();
    sreset = 1'b0;
    checks++; if (state_dbg !== IDLE || count !== 8'd0 || tick !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset state=%0d count=%0d tick=%b running=%b done=%b exp 0/0/0/0/0", state_dbg, count, tick, running, done); end
    do_start();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_after_reset running=%b exp 0", running); end
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = 8'd3; cfg_if.cfg_oneshot = 1'b0;
    start = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    checks++; if (running !== 1'b1 || count !== 8'd0) begin
      errors++; $display("FAIL start_with_cfg running=%b count=%0d exp 1/0", running, count); end
    step(); step(); step();
    checks++; if (count !== 8'd0 || tick !== 1'b1) begin
      errors++; $display("FAIL start_with_cfg_wrap count=%0d tick=%b exp 0/1", count, tick); end
    do_stop();
  endtask

  initial begin
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_period  = '0;
    cfg_if.cfg_oneshot = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_ignored();
    test_edge_periods();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
Programmable interval timer that sits downstream of the free-running counter stage in the core library. It turns a raw cycle count into a configurable period, with periodic or one-shot tick generation, for schedulers, watchdogs and PWM framing. Configuration is accepted over a valid/ready handshake, and start/stop are control strobes.

Parameters:
N, 16, width of period register and count output in bits (N >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
sreset  input  1  synchronous reset, active-high
ce  input  1  count enable; count advances only in cycles where ce=1
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted (combinational from state)
cfg_period  input  N  period in cycles of ce; 0 is illegal for running
cfg_oneshot  input  1  1 = one-shot mode, 0 = periodic mode
start  input  1  start strobe
stop  input  1  stop strobe
count  output  N  current count, 0 .. period-1
running  output  1  high while state is RUN
tick  output  1  one-cycle pulse at end of each period
done  output  1  sticky one-shot completion flag

Behaviour:
- Reset (sreset=1 at an edge):
  - state=IDLE, period_reg=0, oneshot_reg=0, count=0, tick=0, done=0.
  - cfg_ready=1 after reset.
  - sreset overrides every other input, including mid-RUN.
- States:
  - IDLE: stopped, count=0.
  - RUN: counting.
  - DONE: one-shot finished, count=0, done=1.
- cfg_ready:
  - cfg_ready=1 in IDLE and DONE; cfg_ready=0 in RUN.
  - Transfer occurs when cfg_valid & cfg_ready at an edge; it latches period_reg and oneshot_reg.
  - A transfer in DONE clears done and moves to IDLE.
- start, accepted only in IDLE or DONE:
  - Uses the effective period: cfg_period if a transfer happens in the same cycle, else period_reg.
  - Effective period != 0: state<=RUN, count<=0, done<=0.
  - Effective period == 0: start is ignored and state is unchanged.
  - start in RUN is ignored; there is no restart.
- RUN, each edge:
  - stop=1: state<=IDLE, count<=0, tick<=0; done unchanged (stays 0).
  - Else if ce=0: count holds, tick<=0.
  - Else if count==period_reg-1:
    - count<=0, tick<=1.
    - If oneshot_reg: state<=DONE, done<=1.
  - Else: count<=count+1, tick<=0.
- tick is registered. It is high for exactly one cycle, in the cycle after the edge on which count wraps to 0.
- Period P with ce held high gives one tick every P cycles. The first tick is P edges after the start edge.
- P=1: count stays 0 and tick is high every cycle while running (periodic mode).
- Simultaneous events:
  - stop and start in IDLE/DONE: stop wins, nothing happens.
  - stop in IDLE/DONE: no effect; done is preserved.
  - Terminal count and stop in the same edge: stop wins, no tick.
- Arithmetic:
  - count is N bits; the compare is against period_reg-1 at N bits.
  - period_reg is nonzero in RUN by construction, so there is no underflow.
  - Maximum period is 2^N-1.
- running = (state==RUN). It is registered via state, with no combinational path from inputs.

Decomposition:
- Package interval_timer_pkg:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, DONE}.
  - localparam for the state encoding width.
- No sub-module. The count register needs synchronous clear and enable, which the existing asynchronous-reset counter does not provide, so counting is implemented inline in one module.

Test Plan:
- Reset and configure: sreset 1 cycle -> count=0, tick=0, done=0, running=0, cfg_ready=1. Then cfg_period=4 with cfg_oneshot=0 and valid for 1 cycle -> period latched.
- Periodic run: start with P=4, ce=1 -> count sequence 0,1,2,3,0,... and tick high every 4th cycle. Then stop -> running=0, count=0.
- One-shot run: cfg P=3 with oneshot=1, then start -> exactly one tick 3 edges after start, done=1, state DONE, cfg_ready=1, no further ticks.
- Invalid and ignored strobes: start with period_reg=0 -> running stays 0. Start plus stop in the same cycle -> no run. cfg_valid during RUN -> cfg_ready=0 and period unchanged.
- ce gating and edge periods: P=1 -> tick every cycle. P=2^N-1 -> count reaches 2^N-2 then wraps. With ce toggling every other cycle at P=2 -> one tick per 4 clk.
- Mid-operation reset: sreset during RUN at count=2 -> next cycle state IDLE, count=0, tick=0, period_reg=0. Subsequent start is ignored until reconfigured.
